rr_lock_arbiter: RTL and testbench

Parametrised, registered round-robin arbiter. It succeeds the combinational fixed-priority arbiter.
- Grants one of NumRequests requesters and holds (locks) the grant while the owner keeps its request high.
- Optional MaxHold timeout preempts an owner so the other requesters are not starved.
- Sits in front of shared resources (bus, memory port, FIFO write side). It drives grant to the requesters and select to the downstream mux.

---
 rtl/rr_lock_arbiter_if.sv | 30 +++
 rtl/rr_lock_arbiter.sv | 130 +++++++++++++
 tb/tb_rr_lock_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_lock_arbiter_if.sv
// Requester-side bus for rr_lock_arbiter.
//   request     : one bit per requester, high while it wants or holds the resource
//   grant       : one-hot (or zero) owner vector
//   select      : binary index of the owner, 0 when nothing is granted
//   grant_valid : high while some requester owns the resource
//   grant_count : per-requester new-grant counters (ARB_GRANT_CNT_EN only)
// Modports: master = requester side, slave = arbiter side.
interface rr_lock_arbiter_if #(
    parameter int unsigned NumRequests = 4
`ifdef ARB_GRANT_CNT_EN
    ,
    parameter int unsigned CntWidth = 16
`endif
);
    localparam int unsigned SelW = (NumRequests > 1) ? $clog2(NumRequests) : 1;

    logic [NumRequests-1:0] request;
    logic [NumRequests-1:0] grant;
    logic [SelW-1:0]        select;
    logic                   grant_valid;
`ifdef ARB_GRANT_CNT_EN
    logic [NumRequests*CntWidth-1:0] grant_count;

    modport master (output request, input grant, input select, input grant_valid, input grant_count);
    modport slave  (input request, output grant, output select, output grant_valid, output grant_count);
`else
    modport master (output request, input grant, input select, input grant_valid);
    modport slave  (input request, output grant, output select, output grant_valid);
`endif
endinterface

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter with grant locking and optional hold timeout.
// The owner keeps the grant while its request stays high; with MaxHold > 0 an
// owner that has held for MaxHold cycles is preempted if anyone else is waiting.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_lock_arbiter_if.slave (request in; grant/select/grant_valid out,
//          plus grant_count when built with ARB_GRANT_CNT_EN)
// Build option: define ARB_GRANT_CNT_EN to add per-requester CntWidth-bit
// counters of newly registered grants, exposed on bus.grant_count.
module rr_lock_arbiter #(
    parameter int unsigned NumRequests = 4,
    parameter int unsigned MaxHold     = 0,
    parameter int unsigned CntWidth    = 16
) (
    input  logic              clk,
    input  logic              rst,
    rr_lock_arbiter_if.slave  bus
);
    localparam int unsigned SelW  = (NumRequests > 1) ? $clog2(NumRequests) : 1;
    localparam int unsigned HoldW = (MaxHold > 1) ? $clog2(MaxHold) : 1;

    // Elaboration-time parameter sanity.
    if (NumRequests == 0 || NumRequests > 64) begin : g_bad_num_requests
        $error("rr_lock_arbiter: NumRequests must be 1..64");
    end
    if (CntWidth == 0) begin : g_bad_cnt_width
        $error("rr_lock_arbiter: CntWidth must be at least 1");
    end

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t                 state;
    logic [SelW-1:0]        ptr;        // last winner; equals the owner while GRANTED
    logic [HoldW-1:0]       hold_cnt;
    logic [NumRequests-1:0] grant_q;
    logic [SelW-1:0]        select_q;
    logic                   valid_q;

    logic [NumRequests-1:0] others;
    logic                   owner_req;
    logic                   at_limit;
    logic                   need_arb;
    logic                   win_found;
    logic [SelW-1:0]        win_idx;

    // Excluding the current owner from the scan covers all three cases: in IDLE
    // grant is zero, on release the owner's bit is already low, and on
    // preemption the owner must not win again.
    assign others    = bus.request & ~grant_q;
    assign owner_req = |(bus.request & grant_q);
    assign at_limit  = (MaxHold != 0) && (hold_cnt == HoldW'(MaxHold - 1));
    assign need_arb  = (state == IDLE) || !owner_req || at_limit;

    // Round-robin scan starting just after ptr, wrapping modulo NumRequests.
    always_comb begin : arb_scan
        int unsigned            idx;
        logic [NumRequests-1:0] shifted;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        shifted   = '0;
        for (int unsigned off = 1; off <= NumRequests; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= NumRequests) begin
                idx = idx - NumRequests;
            end
            shifted = others >> idx;
            if (!win_found && shifted[0]) begin
                win_found = 1'b1;
                win_idx   = SelW'(idx);
            end
        end
    end

    // Arbitration state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= SelW'(NumRequests - 1);
            hold_cnt <= '0;
            grant_q  <= '0;
            select_q <= '0;
            valid_q  <= 1'b0;
        end else if (need_arb && win_found) begin
            state    <= GRANTED;
            ptr      <= win_idx;
            hold_cnt <= '0;
            grant_q  <= NumRequests'(1) << win_idx;
            select_q <= win_idx;
            valid_q  <= 1'b1;
        end else if (need_arb && !owner_req) begin
            // Released (or idle) with nobody waiting.
            state    <= IDLE;
            hold_cnt <= '0;
            grant_q  <= '0;
            select_q <= '0;
            valid_q  <= 1'b0;
        end else if ((MaxHold != 0) && !at_limit) begin
            // Owner keeps the grant; the count saturates at MaxHold-1.
            hold_cnt <= hold_cnt + HoldW'(1);
        end
    end

    assign bus.grant       = grant_q;
    assign bus.select      = select_q;
    assign bus.grant_valid = valid_q;

`ifdef ARB_GRANT_CNT_EN
    logic [NumRequests*CntWidth-1:0] cnt_q;

    // Count newly registered grants only; held cycles leave the counters alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (need_arb && win_found) begin
            for (int unsigned i = 0; i < NumRequests; i++) begin
                if (SelW'(i) == win_idx) begin
                    cnt_q[i*CntWidth +: CntWidth] <= cnt_q[i*CntWidth +: CntWidth] + CntWidth'(1);
                end
            end
        end
    end

    assign bus.grant_count = cnt_q;
`endif
endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: two instances (MaxHold=0 and
// MaxHold=4) share one request stream and are compared every cycle against a
// behavioural owner/pointer model, plus directed checks of the key scenarios.
module tb_rr_lock_arbiter;
    localparam int N    = 4;
    localparam int CntW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_lock_arbiter_if #(.NumRequests(N)
`ifdef ARB_GRANT_CNT_EN
        , .CntWidth(CntW)
`endif
    ) bus0 ();

    rr_lock_arbiter_if #(.NumRequests(N)
`ifdef ARB_GRANT_CNT_EN
        , .CntWidth(CntW)
`endif
    ) bus1 ();

    rr_lock_arbiter #(.NumRequests(N), .MaxHold(0), .CntWidth(CntW)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    rr_lock_arbiter #(.NumRequests(N), .MaxHold(4), .CntWidth(CntW)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: current owner (-1 = none), last winner, cycles held, grant counts.
    int m_owner [2];
    int m_ptr   [2];
    int m_held  [2];
    int m_cnt   [2][N];
    int m_maxh  [2] = '{0, 4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input bit rs);
        int rq;
        int cand;
        int w;
        int idx;
        bit holding;
        rq = 32'(r);
        for (int d = 0; d < 2; d++) begin
            if (rs) begin
                m_owner[d] = -1;
                m_ptr[d]   = N - 1;
                m_held[d]  = 0;
                for (int i = 0; i < N; i++) m_cnt[d][i] = 0;
            end else begin
                holding = (m_owner[d] >= 0) && (((rq >> m_owner[d]) & 1) != 0);
                cand    = holding ? (rq & ~(1 << m_owner[d])) : rq;
                if (holding && !(m_maxh[d] > 0 && m_held[d] >= m_maxh[d] - 1 && cand != 0)) begin
                    m_held[d] = m_held[d] + 1;
                    if (m_maxh[d] > 0 && m_held[d] > m_maxh[d] - 1) m_held[d] = m_maxh[d] - 1;
                end else begin
                    w = -1;
                    for (int i = 1; i <= N; i++) begin
                        idx = (m_ptr[d] + i) % N;
                        if (w < 0 && ((cand >> idx) & 1) != 0) w = idx;
                    end
                    if (w >= 0) begin
                        m_owner[d]    = w;
                        m_ptr[d]      = w;
                        m_held[d]     = 0;
                        m_cnt[d][w]   = (m_cnt[d][w] + 1) % (1 << CntW);
                    end else begin
                        m_owner[d] = -1;
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_grant(input int d);
        return (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0;
    endfunction

    task automatic check_all();
        check("dut0 grant", 32'(bus0.grant), exp_grant(0));
        check("dut0 select", 32'(bus0.select), (m_owner[0] >= 0) ? 32'(m_owner[0]) : 32'd0);
        check("dut0 valid", 32'(bus0.grant_valid), 32'(m_owner[0] >= 0));
        check("dut0 onehot0", 32'($onehot0(bus0.grant)), 32'd1);
        check("dut1 grant", 32'(bus1.grant), exp_grant(1));
        check("dut1 select", 32'(bus1.select), (m_owner[1] >= 0) ? 32'(m_owner[1]) : 32'd0);
        check("dut1 valid", 32'(bus1.grant_valid), 32'(m_owner[1] >= 0));
        check("dut1 onehot0", 32'($onehot0(bus1.grant)), 32'd1);
`ifdef ARB_GRANT_CNT_EN
        for (int i = 0; i < N; i++) begin
            check("dut0 count", 32'(bus0.grant_count[i*CntW +: CntW]), 32'(m_cnt[0][i]));
            check("dut1 count", 32'(bus1.grant_count[i*CntW +: CntW]), 32'(m_cnt[1][i]));
        end
`endif
    endtask

    // Drive inputs at the falling edge, let the DUT sample, compare 1 time unit later.
    task automatic step(input logic [N-1:0] r, input bit rs);
        @(negedge clk);
        bus0.request = r;
        bus1.request = r;
        rst          = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        check_all();
    endtask

    initial begin
        logic [N-1:0] r;
        bus0.request = '0;
        bus1.request = '0;

        // Reset state.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("reset grant", 32'(bus0.grant), 32'd0);
        check("reset valid", 32'(bus1.grant_valid), 32'd0);

        // First grant after one cycle; requester 0 has top priority but is idle.
        step(4'b1010, 1'b0);
        check("first grant", 32'(bus0.grant), 32'h2);
        check("first select", 32'(bus0.select), 32'd1);
        check("first valid", 32'(bus0.grant_valid), 32'd1);

        // Locked owner holds, then hands over with no idle cycle.
        for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);
        check("lock held", 32'(bus0.grant), 32'h2);
        step(4'b1101, 1'b0);
        check("handover grant", 32'(bus0.grant), 32'h4);
        check("handover select", 32'(bus0.select), 32'd2);

        // Wrap from owner 3 back to requester 0.
        step(4'b1001, 1'b0);
        check("owner 3", 32'(bus0.grant), 32'h8);
        step(4'b0101, 1'b0);
        check("wrap grant", 32'(bus0.grant), 32'h1);
        check("wrap select", 32'(bus0.select), 32'd0);

        // Timeout rotation every 4 cycles with everyone requesting.
        step(4'b0000, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            step(4'b1111, 1'b0);
            check("rotate", 32'(bus1.grant), 32'd1 << (((k - 1) / 4) % 4));
        end

        // Lone requester is never preempted; reset mid-grant; restart at requester 0.
        step(4'b0000, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(4'b0100, 1'b0);
            check("lone owner", 32'(bus1.grant), 32'h4);
        end
        step(4'b0100, 1'b1);
        check("midgrant reset grant", 32'(bus1.grant), 32'd0);
        check("midgrant reset select", 32'(bus1.select), 32'd0);
        step(4'b1111, 1'b0);
        check("post reset grant", 32'(bus1.grant), 32'h1);

`ifdef ARB_GRANT_CNT_EN
        // Five separate grants to requester 0 wrap a 2-bit counter to 1; holds do not count.
        step(4'b0000, 1'b1);
        for (int j = 0; j < 5; j++) begin
            step(4'b0001, 1'b0);
            if (j == 0) begin
                step(4'b0001, 1'b0);
                step(4'b0001, 1'b0);
            end
            step(4'b0000, 1'b0);
        end
        check("cnt0 wrap", 32'(bus1.grant_count[1:0]), 32'd1);
        check("cnt others", 32'(bus1.grant_count[7:2]), 32'd0);
`endif

        // Randomised traffic: mostly small changes so owners hold for a while.
        r = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            else if ($urandom_range(0, 2) == 0) r = r ^ (4'b0001 << $urandom_range(0, 3));
            step(r, ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
